// File: rtl/bitstream_byte_packer_if.sv
// Stream bundle for bitstream_byte_packer: encoder byte groups in, valid/ready bytes out.
// The master side is the encoder/frame-writer environment, the slave side is the packer.
interface bitstream_byte_packer_if #(
    parameter int unsigned BYTE_WIDTH      = 8,
    parameter int unsigned FIFO_DEPTH_LOG2 = 5,
    parameter int unsigned CNT_WIDTH       = 32
);
    logic                     in_flag_first;
    logic [BYTE_WIDTH-1:0]    in_bit_1;
    logic [BYTE_WIDTH-1:0]    in_bit_2;
    logic [BYTE_WIDTH-1:0]    in_bit_3;
    logic [BYTE_WIDTH-1:0]    in_bit_4;
    logic [BYTE_WIDTH-1:0]    in_bit_5;
    logic [2:0]               in_flag_bitstream;
    logic                     in_flag_last;
    logic [BYTE_WIDTH-1:0]    out_byte;
    logic                     out_valid;
    logic                     out_ready;
    logic                     out_last;
    logic                     out_done;
    logic                     overflow;
    logic [FIFO_DEPTH_LOG2:0] fill_level;
    logic [CNT_WIDTH-1:0]     byte_count;

    modport master (
        output in_flag_first, in_bit_1, in_bit_2, in_bit_3, in_bit_4, in_bit_5,
               in_flag_bitstream, in_flag_last, out_ready,
        input  out_byte, out_valid, out_last, out_done, overflow, fill_level, byte_count
    );

    modport slave (
        input  in_flag_first, in_bit_1, in_bit_2, in_bit_3, in_bit_4, in_bit_5,
               in_flag_bitstream, in_flag_last, out_ready,
        output out_byte, out_valid, out_last, out_done, overflow, fill_level, byte_count
    );
endinterface

// File: rtl/bitstream_byte_packer.sv
// Queues 0..5 encoder bytes per cycle in a circular FIFO and streams them out one per cycle.
// Define PACKER_STATS_EN to enable the saturating per-frame byte_count statistic.
module bitstream_byte_packer #(
    parameter int unsigned BYTE_WIDTH      = 8,
    parameter int unsigned FIFO_DEPTH_LOG2 = 5,
    parameter int unsigned CNT_WIDTH       = 32
) (
    input  logic                  top_clk,
    input  logic                  top_reset,
    bitstream_byte_packer_if.slave bus
);
    localparam int unsigned AW    = FIFO_DEPTH_LOG2;
    localparam int unsigned DEPTH = 1 << AW;

    typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

    state_t                state;
    logic [BYTE_WIDTH-1:0] mem [DEPTH];
    logic [BYTE_WIDTH-1:0] grp [5];
    logic [AW-1:0]         rd_ptr;
    logic [AW-1:0]         wr_ptr;
    logic [AW:0]           count;
    logic [AW:0]           n_acc;
    logic [2:0]            n_req;
    logic                  write_en;
    logic                  fits;
    logic                  pop;
    logic                  done_q;
    logic                  ovf_q;

    assign grp[0] = bus.in_bit_1;
    assign grp[1] = bus.in_bit_2;
    assign grp[2] = bus.in_bit_3;
    assign grp[3] = bus.in_bit_4;
    assign grp[4] = bus.in_bit_5;

    // Free space is judged on the pre-pop count, so a same-cycle pop never makes room.
    always_comb begin
        n_req    = (bus.in_flag_bitstream > 3'd5) ? 3'd0 : bus.in_flag_bitstream;
        write_en = bus.in_flag_first || (state == RUN);
        fits     = (AW+1)'(n_req) <= ((AW+1)'(DEPTH) - count);
        n_acc    = (write_en && fits) ? (AW+1)'(n_req) : '0;
        pop      = (count != '0) && bus.out_ready;
    end

    always_ff @(posedge top_clk) begin
        for (int unsigned i = 0; i < 5; i++) begin
            if (i < 32'(n_acc)) mem[wr_ptr + AW'(i)] <= grp[i];
        end
    end

    always_ff @(posedge top_clk or posedge top_reset) begin
        if (top_reset) begin
            state  <= RUN;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            ovf_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            rd_ptr <= rd_ptr + AW'(pop);
            wr_ptr <= wr_ptr + AW'(n_acc);
            count  <= count + n_acc - (AW+1)'(pop);
            done_q <= 1'b0;

            if (write_en && !fits)
                ovf_q <= 1'b1;
            else if (bus.in_flag_first)
                ovf_q <= 1'b0;

            if (bus.in_flag_first) begin
                state <= RUN;
            end else begin
                case (state)
                    RUN: if (bus.in_flag_last) state <= DRAIN;
                    DRAIN: begin
                        if ((count == '0) || (pop && (count == (AW+1)'(1)))) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef PACKER_STATS_EN
    logic [CNT_WIDTH-1:0] stat_cnt;

    always_ff @(posedge top_clk or posedge top_reset) begin
        if (top_reset)
            stat_cnt <= '0;
        else if (bus.in_flag_first)
            stat_cnt <= '0;
        else if (pop && (stat_cnt != '1))
            stat_cnt <= stat_cnt + CNT_WIDTH'(1);
    end

    assign bus.byte_count = stat_cnt;
`else
    assign bus.byte_count = CNT_WIDTH'(0);
`endif

    assign bus.out_valid  = (count != '0);
    assign bus.out_byte   = mem[rd_ptr];
    assign bus.out_last   = (state == DRAIN) && (count == (AW+1)'(1));
    assign bus.out_done   = done_q;
    assign bus.overflow   = ovf_q;
    assign bus.fill_level = count;
endmodule

// File: tb/tb_bitstream_byte_packer.sv
// Self-checking bench for bitstream_byte_packer: directed vector table, hand-written
// overflow/wrap/reset sequences and randomized traffic against a queue-based model.
module tb_bitstream_byte_packer;
    localparam int unsigned BW    = 8;
    localparam int unsigned LG    = 5;
    localparam int unsigned CW    = 32;
    localparam int          DEPTH = 32;
    localparam int          PH_RUN = 0, PH_DRAIN = 1, PH_DONE = 2;

    logic top_clk = 1'b0;
    logic top_reset;

    bitstream_byte_packer_if #(.BYTE_WIDTH(BW), .FIFO_DEPTH_LOG2(LG), .CNT_WIDTH(CW)) bus ();

    bitstream_byte_packer #(.BYTE_WIDTH(BW), .FIFO_DEPTH_LOG2(LG), .CNT_WIDTH(CW)) dut (
        .top_clk   (top_clk),
        .top_reset (top_reset),
        .bus       (bus)
    );

    always #5 top_clk = ~top_clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: byte queue plus frame phase, evaluated once per clock edge.
    logic [7:0]  mq [$];
    int          m_phase;
    bit          m_ovf;
    bit          m_done;
    logic [31:0] m_bc;

    typedef struct {
        bit             first;
        bit             last;
        logic [2:0]     n;
        logic [4:0][7:0] b;
        bit             ready;
        bit             e_valid;
        logic [7:0]     e_byte;
        int             e_fill;
        bit             e_last;
        bit             e_done;
        bit             e_ovf;
    } vec_t;

    vec_t tbl [$];

    function automatic vec_t mk(bit f, bit l, logic [2:0] n, logic [4:0][7:0] b, bit r,
                                bit ev, logic [7:0] eb, int ef, bit el, bit ed, bit eo);
        vec_t v;
        v.first = f; v.last = l; v.n = n; v.b = b; v.ready = r;
        v.e_valid = ev; v.e_byte = eb; v.e_fill = ef; v.e_last = el; v.e_done = ed; v.e_ovf = eo;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_phase = PH_RUN;
        m_ovf   = 1'b0;
        m_done  = 1'b0;
        m_bc    = '0;
    endtask

    task automatic compare_model();
        chk("valid", 32'(bus.out_valid), 32'(mq.size() != 0));
        if (mq.size() != 0) chk("byte", 32'(bus.out_byte), 32'(mq[0]));
        chk("fill", 32'(bus.fill_level), 32'(mq.size()));
        chk("last", 32'(bus.out_last), 32'((m_phase == PH_DRAIN) && (mq.size() == 1)));
        chk("done", 32'(bus.out_done), 32'(m_done));
        chk("overflow", 32'(bus.overflow), 32'(m_ovf));
`ifdef PACKER_STATS_EN
        chk("byte_count", bus.byte_count, m_bc);
`else
        chk("byte_count", bus.byte_count, 32'd0);
`endif
    endtask

    task automatic step(input bit first, input bit last, input logic [2:0] n,
                        input logic [4:0][7:0] b, input bit ready);
        int sz;
        int take;
        bit pop;
        bit drop;
        bus.in_flag_first     = first;
        bus.in_flag_last      = last;
        bus.in_flag_bitstream = n;
        bus.in_bit_1 = b[0]; bus.in_bit_2 = b[1]; bus.in_bit_3 = b[2];
        bus.in_bit_4 = b[3]; bus.in_bit_5 = b[4];
        bus.out_ready = ready;

        sz   = mq.size();
        pop  = (sz != 0) && ready;
        take = (int'(n) > 5) ? 0 : int'(n);
        drop = 1'b0;
        m_done = 1'b0;
        if (pop) void'(mq.pop_front());
        if (first || m_phase == PH_RUN) begin
            if (take <= DEPTH - sz) begin
                for (int i = 0; i < take; i++) mq.push_back(b[i]);
            end else begin
                drop = 1'b1;
            end
        end
        if (first) begin
            m_phase = PH_RUN;
            m_ovf   = 1'b0;
            m_bc    = '0;
        end else begin
            if (pop && m_bc != 32'hFFFF_FFFF) m_bc = m_bc + 32'd1;
            if (m_phase == PH_RUN && last) begin
                m_phase = PH_DRAIN;
            end else if (m_phase == PH_DRAIN && (sz == 0 || (pop && sz == 1))) begin
                m_phase = PH_DONE;
                m_done  = 1'b1;
            end
        end
        if (drop) m_ovf = 1'b1;

        @(posedge top_clk);
        #1;
        compare_model();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0][7:0] rb;
        logic [4:0][7:0] z;
        z = '0;

        top_reset = 1'b1;
        bus.in_flag_first = 1'b0; bus.in_flag_last = 1'b0; bus.in_flag_bitstream = 3'd0;
        bus.in_bit_1 = '0; bus.in_bit_2 = '0; bus.in_bit_3 = '0; bus.in_bit_4 = '0; bus.in_bit_5 = '0;
        bus.out_ready = 1'b1;
        model_reset();
        @(posedge top_clk);
        @(posedge top_clk);
        #1;
        compare_model();
        @(negedge top_clk);
        top_reset = 1'b0;

        // Single group drain, last/done timing, empty-drain, illegal counts, first+last together.
        tbl.push_back(mk(0,0,3'd3,{8'h00,8'h00,8'hA3,8'hA2,8'hA1},1, 1,8'hA1,3,0,0,0));
        tbl.push_back(mk(0,0,3'd0,z,1, 1,8'hA2,2,0,0,0));
        tbl.push_back(mk(0,0,3'd0,z,1, 1,8'hA3,1,0,0,0));
        tbl.push_back(mk(0,0,3'd0,z,1, 0,8'h00,0,0,0,0));
        tbl.push_back(mk(0,1,3'd2,{8'h00,8'h00,8'h00,8'h22,8'h11},1, 1,8'h11,2,0,0,0));
        tbl.push_back(mk(0,0,3'd0,z,1, 1,8'h22,1,1,0,0));
        tbl.push_back(mk(0,0,3'd0,z,1, 0,8'h00,0,0,1,0));
        tbl.push_back(mk(0,0,3'd0,z,1, 0,8'h00,0,0,0,0));
        tbl.push_back(mk(1,0,3'd0,z,1, 0,8'h00,0,0,0,0));
        tbl.push_back(mk(0,1,3'd0,z,1, 0,8'h00,0,0,0,0));
        tbl.push_back(mk(0,0,3'd0,z,1, 0,8'h00,0,0,1,0));
        tbl.push_back(mk(0,0,3'd0,z,1, 0,8'h00,0,0,0,0));
        tbl.push_back(mk(1,0,3'd0,z,1, 0,8'h00,0,0,0,0));
        tbl.push_back(mk(0,0,3'd6,{8'hFF,8'hFF,8'hFF,8'hFF,8'hFF},0, 0,8'h00,0,0,0,0));
        tbl.push_back(mk(0,0,3'd7,{8'hEE,8'hEE,8'hEE,8'hEE,8'hEE},0, 0,8'h00,0,0,0,0));
        tbl.push_back(mk(1,1,3'd1,{8'h00,8'h00,8'h00,8'h00,8'h5A},0, 1,8'h5A,1,0,0,0));
        tbl.push_back(mk(0,0,3'd0,z,0, 1,8'h5A,1,0,0,0));
        tbl.push_back(mk(0,0,3'd0,z,1, 0,8'h00,0,0,0,0));

        foreach (tbl[k]) begin
            step(tbl[k].first, tbl[k].last, tbl[k].n, tbl[k].b, tbl[k].ready);
            chk($sformatf("tbl%0d.valid", k), 32'(bus.out_valid), 32'(tbl[k].e_valid));
            if (tbl[k].e_valid) chk($sformatf("tbl%0d.byte", k), 32'(bus.out_byte), 32'(tbl[k].e_byte));
            chk($sformatf("tbl%0d.fill", k), 32'(bus.fill_level), 32'(tbl[k].e_fill));
            chk($sformatf("tbl%0d.last", k), 32'(bus.out_last), 32'(tbl[k].e_last));
            chk($sformatf("tbl%0d.done", k), 32'(bus.out_done), 32'(tbl[k].e_done));
            chk($sformatf("tbl%0d.ovf", k), 32'(bus.overflow), 32'(tbl[k].e_ovf));
        end

        // Fill to 30 with the consumer stalled, then a group that cannot fit.
        for (int k = 0; k < 6; k++) begin
            for (int j = 0; j < 5; j++) rb[j] = 8'(k * 5 + j + 1);
            step(0, 0, 3'd5, rb, 0);
        end
        chk("prefill.fill", 32'(bus.fill_level), 32'd30);
        chk("prefill.ovf", 32'(bus.overflow), 32'd0);
        for (int j = 0; j < 5; j++) rb[j] = 8'hC0 + 8'(j);
        step(0, 0, 3'd5, rb, 0);
        chk("drop.fill", 32'(bus.fill_level), 32'd30);
        chk("drop.ovf", 32'(bus.overflow), 32'd1);
        step(1, 0, 3'd0, z, 0);
        chk("first.ovf_clear", 32'(bus.overflow), 32'd0);

        // Drain to 2 entries, then push across the pointer wrap while draining.
        for (int k = 0; k < 28; k++) step(0, 0, 3'd0, z, 1);
        chk("wrap.fill_pre", 32'(bus.fill_level), 32'd2);
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < 5; j++) rb[j] = 8'h40 + 8'(k * 5 + j);
            step(0, 0, 3'd5, rb, 1);
        end
        chk("wrap.fill", 32'(bus.fill_level), 32'd18);
        for (int k = 0; k < 18; k++) step(0, 0, 3'd0, z, 1);
        chk("wrap.empty", 32'(bus.fill_level), 32'd0);
        chk("wrap.ovf", 32'(bus.overflow), 32'd0);

        // Randomized traffic with occasional frame ends and restarts.
        step(1, 0, 3'd0, z, 1);
        for (int k = 0; k < 400; k++) begin
            bit f;
            bit l;
            for (int j = 0; j < 5; j++) rb[j] = 8'($urandom);
            f = ($urandom_range(0, 24) == 0);
            l = ($urandom_range(0, 15) == 0);
            step(f, l, 3'($urandom_range(0, 7)), rb, bit'($urandom_range(0, 1)));
        end

        // Asynchronous reset while holding 10 bytes.
        step(1, 0, 3'd0, z, 1);
        while (mq.size() != 0 && n_checks < 100000) step(0, 0, 3'd0, z, 1);
        for (int k = 0; k < 2; k++) begin
            for (int j = 0; j < 5; j++) rb[j] = 8'h90 + 8'(k * 5 + j);
            step(0, 0, 3'd5, rb, 0);
        end
        chk("prereset.fill", 32'(bus.fill_level), 32'd10);
        #3;
        top_reset = 1'b1;
        #1;
        model_reset();
        chk("reset.fill", 32'(bus.fill_level), 32'd0);
        chk("reset.valid", 32'(bus.out_valid), 32'd0);
        chk("reset.byte_count", bus.byte_count, 32'd0);
        chk("reset.ovf", 32'(bus.overflow), 32'd0);
        @(negedge top_clk);
        top_reset = 1'b0;
        step(0, 0, 3'd1, {8'h00,8'h00,8'h00,8'h00,8'h77}, 1);
        step(0, 0, 3'd0, z, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
